// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// from the latched opcode and stalls memory states on mem_ready.
package mipspkg;

  typedef enum logic [5:0] {
    Rtyp  = 6'h00,
    J     = 6'h02,
    BEQZ  = 6'h04,
    ADDI  = 6'h08,
    ADDIU = 6'h09,
    SLTI  = 6'h0a,
    ANDI  = 6'h0c,
    ORI   = 6'h0d,
    XORI  = 6'h0e,
    LUI   = 6'h0f,
    SUBI  = 6'h18,
    LW    = 6'h23,
    SW    = 6'h2b
  } op_t;

  // Registered control word; fetch/memwrite are qualified by mem_ready at the outputs.
  typedef struct packed {
    logic       pcwrite;
    logic       fetch;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       zeroextend;
    logic [3:0] aluop;
    logic       illegal_op;
  } ctrl_t;

endpackage

module mc_maindec
  import mipspkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MEM_WAIT_EN = 1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  op_t                op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               branch,
  output logic               iord,
  output logic               irwrite,
  output logic               memwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               zeroextend,
  output logic [ALUOP_W-1:0] aluopout,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_out
);

  if (ALUOP_W < 4) begin : g_bad_aluop_w
    $error("mc_maindec: ALUOP_W must be at least 4");
  end
  if (STATE_W < 4) begin : g_bad_state_w
    $error("mc_maindec: STATE_W must be at least 4");
  end

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    IMMEX   = 4'd8,
    IMMWB   = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11,
    ILLEGAL = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_LUI  = 4'b0111;
  localparam logic [3:0] ALU_FUNC = 4'b1111;

  function automatic logic [3:0] imm_aluop(input op_t o);
    logic [3:0] a;
    a = ALU_ADD;
    case (o)
      ADDI, ADDIU: a = ALU_ADD;
      SUBI:        a = ALU_SUB;
      SLTI:        a = ALU_SLT;
      ANDI:        a = ALU_AND;
      ORI:         a = ALU_OR;
      XORI:        a = ALU_XOR;
      LUI:         a = ALU_LUI;
      default:     a = ALU_ADD;
    endcase
    return a;
  endfunction

  function automatic logic imm_zext(input op_t o);
    return (o == ANDI) || (o == ORI) || (o == XORI) || (o == LUI);
  endfunction

  function automatic ctrl_t ctrl_of(input state_t s, input op_t o);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch   = 1'b1;
        c.alusrcb = 2'b01;
        c.aluop   = ALU_ADD;
      end
      DECODE: begin
        c.alusrcb = 2'b11;
        c.aluop   = ALU_ADD;
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = ALU_ADD;
      end
      MEMRD: c.iord = 1'b1;
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_FUNC;
      end
      ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      IMMEX: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = 2'b10;
        c.aluop      = imm_aluop(o);
        c.zeroextend = imm_zext(o);
      end
      // Keep extend mode and ALU op stable through writeback.
      IMMWB: begin
        c.regwrite   = 1'b1;
        c.aluop      = imm_aluop(o);
        c.zeroextend = imm_zext(o);
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_SUB;
        c.branch  = 1'b1;
        c.pcsrc   = 2'b01;
      end
      JUMP: begin
        c.pcwrite = 1'b1;
        c.pcsrc   = 2'b10;
      end
      ILLEGAL: c.illegal_op = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state, nxt;
  op_t    op_q, op_nxt;
  ctrl_t  ctrl_q;
  logic   rdy;
  logic   en;

  assign rdy    = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign op_nxt = (state == DECODE) ? op : op_q;

  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH: nxt = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          LW, SW:                                    nxt = MEMADR;
          Rtyp:                                      nxt = EXECUTE;
          ADDI, ADDIU, SUBI, SLTI, ANDI, ORI, XORI, LUI: nxt = IMMEX;
          BEQZ:                                      nxt = BRANCH;
          J:                                         nxt = JUMP;
          default:                                   nxt = ILLEGAL;
        endcase
      end
      MEMADR:  nxt = (op_q == LW) ? MEMRD : MEMWR;
      MEMRD:   nxt = rdy ? MEMWB : MEMRD;
      MEMWR:   nxt = rdy ? FETCH : MEMWR;
      EXECUTE: nxt = ALUWB;
      IMMEX:   nxt = IMMWB;
      default: nxt = FETCH;
    endcase
  end

  // Control word is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= FETCH;
      op_q   <= Rtyp;
      ctrl_q <= ctrl_of(FETCH, Rtyp);
    end else begin
      state  <= nxt;
      op_q   <= op_nxt;
      ctrl_q <= ctrl_of(nxt, op_nxt);
    end
  end

  // Reset low or a corrupted state encoding silences every output.
  assign en = reset && (state <= ILLEGAL);

  assign pcwrite    = en & (ctrl_q.pcwrite | (ctrl_q.fetch & rdy));
  assign irwrite    = en & ctrl_q.fetch & rdy;
  assign memwrite   = en & ctrl_q.memwrite & rdy;
  assign branch     = en & ctrl_q.branch;
  assign iord       = en & ctrl_q.iord;
  assign memtoreg   = en & ctrl_q.memtoreg;
  assign regdst     = en & ctrl_q.regdst;
  assign regwrite   = en & ctrl_q.regwrite;
  assign alusrca    = en & ctrl_q.alusrca;
  assign alusrcb    = en ? ctrl_q.alusrcb : 2'b00;
  assign pcsrc      = en ? ctrl_q.pcsrc : 2'b00;
  assign zeroextend = en & ctrl_q.zeroextend;
  assign illegal_op = en & ctrl_q.illegal_op;
  assign aluopout   = en ? ALUOP_W'(ctrl_q.aluop) : '0;
  assign state_out  = en ? STATE_W'(state) : '0;

endmodule

// File: tb/tb_mc_maindec.sv
// Directed cycle-by-cycle check of the multicycle main decoder: each step drives
// inputs after the falling edge and compares state and the full control word.
module tb_mc_maindec;
  import mipspkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  op_t        op = Rtyp;
  logic       mem_ready = 1'b1;
  logic       pcwrite, branch, iord, irwrite, memwrite, memtoreg, regdst, regwrite;
  logic       alusrca, zeroextend, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] aluopout;
  logic [3:0] state_out;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_maindec #(.ALUOP_W(4), .MEM_WAIT_EN(1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .iord(iord), .irwrite(irwrite),
    .memwrite(memwrite), .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .zeroextend(zeroextend),
    .aluopout(aluopout), .illegal_op(illegal_op), .state_out(state_out)
  );

  logic [18:0] outs;
  assign outs = {pcwrite, branch, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
                 alusrca, alusrcb, pcsrc, zeroextend, aluopout, illegal_op};

  function automatic logic [18:0] ctl(input logic pcw, br, io, irw, mw, m2r, rd, rw, asa,
                                      input logic [1:0] asb, pcs, input logic ze,
                                      input logic [3:0] alu, input logic ill);
    return {pcw, br, io, irw, mw, m2r, rd, rw, asa, asb, pcs, ze, alu, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input op_t o, input logic rdy, input logic rst,
                      input logic [3:0] es, input logic [18:0] ec);
    @(negedge clk);
    op = o; mem_ready = rdy; reset = rst;
    #1;
    chk({tag, ".st"}, 32'(state_out), 32'(es));
    chk({tag, ".ctl"}, 32'(outs), 32'(ec));
  endtask

  logic [18:0] c0, f1, f0, dec, exe, awb, madr, mrd, mwb, mwr1, mwr0;
  logic [18:0] ix_ori, iw_ori, ix_subi, iw_subi, brn, jmp, ill;
  op_t bad;

  initial begin
    c0      = '0;
    f1      = ctl(1,0,0,1,0,0,0,0,0, 2'b01, 2'b00, 0, 4'b0000, 0);
    f0      = ctl(0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 0, 4'b0000, 0);
    dec     = ctl(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 0, 4'b0000, 0);
    exe     = ctl(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 0, 4'b1111, 0);
    awb     = ctl(0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 0, 4'b0000, 0);
    madr    = ctl(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 0, 4'b0000, 0);
    mrd     = ctl(0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 0, 4'b0000, 0);
    mwb     = ctl(0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 0, 4'b0000, 0);
    mwr1    = ctl(0,0,1,0,1,0,0,0,0, 2'b00, 2'b00, 0, 4'b0000, 0);
    mwr0    = ctl(0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 0, 4'b0000, 0);
    ix_ori  = ctl(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 1, 4'b0101, 0);
    iw_ori  = ctl(0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 1, 4'b0101, 0);
    ix_subi = ctl(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 0, 4'b0001, 0);
    iw_subi = ctl(0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 0, 4'b0001, 0);
    brn     = ctl(0,1,0,0,0,0,0,0,1, 2'b00, 2'b01, 0, 4'b0001, 0);
    jmp     = ctl(1,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 0, 4'b0000, 0);
    ill     = ctl(0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 4'b0000, 1);
    bad     = op_t'(6'h3f);

    // Reset held low two cycles: everything gated to zero.
    step("rst0", Rtyp, 1, 0, 4'd0, c0);
    step("rst1", Rtyp, 1, 0, 4'd0, c0);
    // R-type: 0,1,6,7 then back to fetch.
    step("r.f",  Rtyp, 1, 1, 4'd0, f1);
    step("r.d",  Rtyp, 1, 1, 4'd1, dec);
    step("r.e",  Rtyp, 1, 1, 4'd6, exe);
    step("r.w",  Rtyp, 1, 1, 4'd7, awb);
    // LW with three wait cycles in MEMRD; op changes after decode are ignored.
    step("lw.f",  LW,   1, 1, 4'd0, f1);
    step("lw.d",  LW,   1, 1, 4'd1, dec);
    step("lw.a",  SW,   1, 1, 4'd2, madr);
    step("lw.r0", Rtyp, 0, 1, 4'd3, mrd);
    step("lw.r1", Rtyp, 0, 1, 4'd3, mrd);
    step("lw.r2", Rtyp, 0, 1, 4'd3, mrd);
    step("lw.r3", Rtyp, 1, 1, 4'd3, mrd);
    step("lw.wb", Rtyp, 1, 1, 4'd4, mwb);
    // SW with a fetch stall, then two wait cycles in MEMWR.
    step("sw.f0", SW, 0, 1, 4'd0, f0);
    step("sw.f",  SW, 1, 1, 4'd0, f1);
    step("sw.d",  SW, 1, 1, 4'd1, dec);
    step("sw.a",  LW, 1, 1, 4'd2, madr);
    step("sw.w0", LW, 0, 1, 4'd5, mwr0);
    step("sw.w1", LW, 0, 1, 4'd5, mwr0);
    step("sw.w2", LW, 1, 1, 4'd5, mwr1);
    // ORI then SUBI back to back.
    step("ori.f",  ORI,  1, 1, 4'd0, f1);
    step("ori.d",  ORI,  1, 1, 4'd1, dec);
    step("ori.x",  SUBI, 1, 1, 4'd8, ix_ori);
    step("ori.w",  SUBI, 1, 1, 4'd9, iw_ori);
    step("subi.f", SUBI, 1, 1, 4'd0, f1);
    step("subi.d", SUBI, 1, 1, 4'd1, dec);
    step("subi.x", ORI,  1, 1, 4'd8, ix_subi);
    step("subi.w", ORI,  1, 1, 4'd9, iw_subi);
    // Branch and jump.
    step("beq.f", BEQZ, 1, 1, 4'd0, f1);
    step("beq.d", BEQZ, 1, 1, 4'd1, dec);
    step("beq.b", Rtyp, 1, 1, 4'd10, brn);
    step("j.f",   J,    1, 1, 4'd0, f1);
    step("j.d",   J,    1, 1, 4'd1, dec);
    step("j.j",   Rtyp, 1, 1, 4'd11, jmp);
    // Undefined op, reset during ILLEGAL: pulse is gated off.
    step("il.f",  bad,  1, 1, 4'd0, f1);
    step("il.d",  bad,  1, 1, 4'd1, dec);
    step("il.rs", Rtyp, 1, 0, 4'd0, c0);
    step("il.f2", bad,  1, 1, 4'd0, f1);
    step("il.d2", bad,  1, 1, 4'd1, dec);
    step("il.x",  Rtyp, 1, 1, 4'd12, ill);
    step("il.f3", Rtyp, 1, 1, 4'd0, f1);
    // Reset while a store is ready: no write strobe.
    step("rw.d",  SW,   1, 1, 4'd1, dec);
    step("rw.a",  SW,   1, 1, 4'd2, madr);
    step("rw.rs", SW,   1, 0, 4'd0, c0);
    step("rw.f",  Rtyp, 1, 1, 4'd0, f1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
- Multicycle main control FSM for the MIPS core. Next generation of the single-cycle main decoder.
- Takes the op_t opcode from the instruction register and sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives datapath enables and mux selects, and stalls on a memory-ready handshake.
- Sits between the instruction register and the shared-memory multicycle datapath. Flags unsupported opcodes instead of leaving them undefined.

Parameters:
- ALUOP_W, 4: width of aluopout.
- MEM_WAIT_EN, 1: 1 means FETCH/MEMRD/MEMWR wait for mem_ready; 0 means mem_ready is treated as constant 1.
- STATE_W, 4: width of state_out debug port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- op  in  op_t  opcode from instruction register (mipspkg enum).
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pcwrite  out  1  unconditional PC load.
- branch  out  1  PC load qualified by datapath zero flag.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  instruction register load.
- memwrite  out  1  data memory write strobe.
- memtoreg  out  1  register write data: 1 = MDR, 0 = ALUOut.
- regdst  out  1  destination register: 1 = rd, 0 = rt.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B: 00 = rt, 01 = const 4, 10 = sign/zero-extended imm, 11 = imm<<2.
- pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- zeroextend  out  1  immediate zero-extend (else sign-extend).
- aluopout  out  ALUOP_W  ALU operation code.
- illegal_op  out  1  one-cycle pulse for an unsupported opcode.
- state_out  out  STATE_W  current state encoding (debug).

Behaviour:
- Reset:
  - reset low at a rising edge sets state = FETCH and op_q = Rtyp.
  - While reset is low, every output is forced to 0, combinationally gated.
  - Reset mid-instruction abandons it; no write strobe is asserted in the cycle reset is low.
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, IMMEX=8, IMMWB=9, BRANCH=10, JUMP=11, ILLEGAL=12.
- Outputs are Moore, except irwrite/pcwrite in FETCH and memwrite in MEMWR, which are ANDed with mem_ready.
- Default for every output not listed for a state is 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=ADD(0000), pcsrc=00. irwrite=pcwrite=mem_ready. Go to DECODE when mem_ready, else hold.
- DECODE: alusrcb=11, aluop=ADD. Latch op into op_q. Next state by op:
  - LW, SW -> MEMADR.
  - Rtyp -> EXECUTE.
  - ADDI, ADDIU, SUBI, SLTI, ANDI, ORI, XORI, LUI -> IMMEX.
  - BEQZ -> BRANCH.
  - J -> JUMP.
  - Any other value -> ILLEGAL.
- MEMADR: alusrca=1, alusrcb=10, aluop=ADD. Go to MEMRD if op_q=LW, else MEMWR.
- MEMRD: iord=1. Go to MEMWB on mem_ready, else hold.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Go to FETCH.
- MEMWR: iord=1, memwrite=mem_ready. Go to FETCH on mem_ready, else hold.
- EXECUTE: alusrca=1, alusrcb=00, aluop=1111 (funct-decoded downstream). Go to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
- IMMEX: alusrca=1, alusrcb=10, aluop per op_q. zeroextend=1 for ANDI/ORI/XORI/LUI only. Go to IMMWB.
  - ADDI/ADDIU: 0000. SUBI: 0001. SLTI: 0010. ANDI: 0100. ORI: 0101. XORI: 0110. LUI: 0111.
- IMMWB: regwrite=1, regdst=0, memtoreg=0. Hold zeroextend and aluop from IMMEX. Go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=0001, branch=1, pcsrc=01. Go to FETCH.
- JUMP: pcwrite=1, pcsrc=10. Go to FETCH.
- ILLEGAL: illegal_op=1 for exactly one cycle, no writes. Go to FETCH; the PC has already advanced by 4.
- aluopout is zero-extended to ALUOP_W when ALUOP_W > 4. ALUOP_W < 4 is unsupported (elaboration error).
- Latency with mem_ready always 1: Rtyp 4, imm 4, LW 5, SW 4, BEQZ 3, J 3 cycles.
- Each wait cycle adds 1 cycle. No strobe repeats while waiting.
- op changes after DECODE have no effect, because op_q is used.
- Illegal states (13..15) go to FETCH with all outputs 0.

Test Plan:
- Reset low 2 cycles then high, mem_ready=1 -> state_out=0 at the first high edge; all outputs 0 while reset is low; irwrite=pcwrite=1 in the first FETCH cycle.
- op=Rtyp, mem_ready=1 -> states 0,1,6,7,0; regwrite=1 and regdst=1 only in cycle 4; aluopout=1111 in EXECUTE.
- op=LW, mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles; iord=1 throughout; a single regwrite pulse with memtoreg=1; total 8 cycles.
- op=SW, mem_ready low 2 cycles in MEMWR -> memwrite=1 in exactly one cycle (the ready cycle); regwrite never 1.
- op=ORI then op=SUBI back-to-back -> ORI: aluopout=0101, zeroextend=1. SUBI: aluopout=0001, zeroextend=0. Each takes 4 cycles.
- Undefined op value in DECODE, then reset low in the next (ILLEGAL) cycle -> illegal_op is 0 because outputs are gated; state_out=0 afterwards. Repeat without reset -> illegal_op=1 for 1 cycle, then FETCH.
